// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Instruction byte layout: {op[3:0], imm[3:0]}
  localparam int INSTR_W = 8;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  localparam int ADDR_W  = 8;

  // Opcode that stops fetching unless overridden at instantiation
  localparam logic [3:0] DEF_HALT_OP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Extract the opcode field of an instruction byte
  function automatic logic [3:0] op_of(input logic [INSTR_W-1:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Purpose: core/memory-side signal bundle of the fetch controller.
// Latency: n/a (wiring only).
// Backpressure: memory stalls via mem_ack; core is paced by core_en pulses.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic               run;
  logic [ADDR_W-1:0]  pc;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] input_ins;
  logic               core_en;
  logic               halted;
  logic               err;

  // Fetch controller side
  modport master (
    input  run, pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, input_ins, core_en, halted, err
  );

  // Core + instruction memory side
  modport slave (
    output run, pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, input_ins, core_en, halted, err
  );

endinterface

// File: rtl/fetch_timer.sv
// Purpose: counts cycles spent waiting for a memory ack (FETCH_TIMEOUT_EN builds only).
// Latency: expired is combinational on the ACK_TIMEOUT-th enabled cycle.
// Backpressure: none; clear has priority over counting.
`ifdef FETCH_TIMEOUT_EN
module fetch_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic CLB,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  // expired marks the last allowed waiting cycle, so the request is held
  // for exactly ACK_TIMEOUT cycles before the owner gives up
  assign expired = enable && (cnt == 8'(ACK_TIMEOUT - 1));

  // Count enabled cycles; saturate once expired so the value never wraps
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (enable && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Purpose: fetches one instruction byte per request and issues it to the core; optional ack timeout via FETCH_TIMEOUT_EN.
// Latency: 1 cycle REQ (zero-wait ack) + 1 cycle ISSUE -> one instruction per 2 cycles.
// Backpressure: mem_req held with stable address until mem_ack; run only gates starting a new request.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int         ACK_TIMEOUT = 15,
  parameter logic [3:0] HALT_OP     = DEF_HALT_OP
) (
  input  logic         clk,
  input  logic         CLB,
  fetch_ctrl_if.master bus
);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] REQ   = S_REQ;
  localparam logic [2:0] ISSUE = S_ISSUE;
  localparam logic [2:0] HALT  = S_HALT;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [2:0] ERR   = S_ERR;
`endif

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ins_q, ins_d;
  logic               mem_req_q;
  logic               core_en_q;
  logic               halted_q;

  // The address is the core's pc; the core keeps it stable while not issuing
  assign bus.mem_addr  = bus.pc;
  assign bus.mem_req   = mem_req_q;
  assign bus.input_ins = ins_q;
  assign bus.core_en   = core_en_q;
  assign bus.halted    = halted_q;

`ifdef FETCH_TIMEOUT_EN
  logic tmr_expired;
  logic err_q;

  // Counter runs only while a request is outstanding and restarts on every new request
  fetch_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .CLB     (CLB),
    .clear   (state_q != REQ),
    .enable  (state_q == REQ),
    .expired (tmr_expired)
  );

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Next-state decode; input_ins only loads on the edge that samples mem_ack in REQ
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    case (state_q)
      IDLE: begin
        if (bus.run) state_d = REQ;
      end
      REQ: begin
        // An ack on the final allowed cycle still wins over the timeout
        if (bus.mem_ack) begin
          state_d = ISSUE;
          ins_d   = bus.mem_rdata;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmr_expired) begin
          state_d = ERR;
        end
`endif
      end
      ISSUE: begin
        // The halt instruction has already been issued by the time we stop
        if (op_of(ins_q) == HALT_OP) state_d = HALT;
        else if (bus.run)            state_d = REQ;
        else                         state_d = IDLE;
      end
      HALT: begin
        if (!bus.run) state_d = IDLE;
      end
`ifdef FETCH_TIMEOUT_EN
      ERR: begin
        state_d = ERR;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register state and outputs decoded from the next state so all outputs are flops
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q   <= IDLE;
      ins_q     <= '0;
      mem_req_q <= 1'b0;
      core_en_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      mem_req_q <= (state_d == REQ);
      core_en_q <= (state_d == ISSUE);
      halted_q  <= (state_d == HALT);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Sticky error flag; ERR has no exit other than reset
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_d == ERR);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl with a memory/core model and randomized traffic.
// Latency: expectations are per transaction: (wait+1) request cycles, then one issue cycle.
// Backpressure: memory ack delay chosen by the bench; core advances pc on each core_en pulse.
module tb_fetch_ctrl;

  localparam logic [3:0] HALT_OP = 4'hF;

  logic clk = 1'b0;
  logic CLB;
  int   checks = 0;
  int   errors = 0;

  // Reference model: instruction memory contents, the core's pc, last issued byte
  logic [7:0] mem [256];
  logic [7:0] pc_m;
  logic [7:0] last_ins;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .ACK_TIMEOUT (15),
    .HALT_OP     (4'hF)
  ) dut (
    .clk (clk),
    .CLB (CLB),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0b required=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%02h required=%02h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and land just after the edge, where outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch transaction, entered while the DUT is requesting.
  // lat = ack wait cycles; run_next = run level seen when leaving issue.
  task automatic do_instr(input int lat, input logic run_next, input logic drop_run);
    logic [7:0] exp_ins;
    for (int i = 0; i < lat; i++) begin
      check1("wait_mem_req", bus.mem_req, 1'b1);
      check8("wait_addr", bus.mem_addr, pc_m);
      check1("wait_core_en", bus.core_en, 1'b0);
      check8("wait_ins_hold", bus.input_ins, last_ins);
      if (drop_run && i == 0) bus.run = 1'b0;
      tick();
    end
    check1("ack_mem_req", bus.mem_req, 1'b1);
    check8("ack_addr", bus.mem_addr, pc_m);
    exp_ins       = mem[pc_m];
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = exp_ins;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'($urandom);
    check1("issue_core_en", bus.core_en, 1'b1);
    check1("issue_mem_req", bus.mem_req, 1'b0);
    check8("issue_ins", bus.input_ins, exp_ins);
    last_ins = exp_ins;
    bus.run  = run_next;
    tick();
    // core consumed the instruction on that edge and moves to the next address
    pc_m   = pc_m + 8'd1;
    bus.pc = pc_m;
    check1("post_core_en", bus.core_en, 1'b0);
    if (exp_ins[7:4] == HALT_OP) begin
      check1("post_halted", bus.halted, 1'b1);
      check1("post_halt_mem_req", bus.mem_req, 1'b0);
    end else begin
      check1("post_mem_req", bus.mem_req, run_next);
      check1("post_not_halted", bus.halted, 1'b0);
    end
  endtask

  initial begin
    bus.run       = 1'b0;
    bus.pc        = 8'h00;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    CLB           = 1'b0;
    pc_m          = 8'h00;
    last_ins      = 8'h00;
    for (int k = 0; k < 256; k++) mem[k] = 8'h00;

    // Reset values while CLB is held low
    repeat (3) tick();
    check1("rst_mem_req", bus.mem_req, 1'b0);
    check1("rst_core_en", bus.core_en, 1'b0);
    check8("rst_ins", bus.input_ins, 8'h00);
    check1("rst_halted", bus.halted, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    CLB = 1'b1;
    tick();
    tick();
    check1("idle_mem_req", bus.mem_req, 1'b0);

    // Ack while idle must not load anything
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hAA;
    tick();
    tick();
    check8("idle_ack_ins", bus.input_ins, 8'h00);
    check1("idle_ack_mem_req", bus.mem_req, 1'b0);
    check1("idle_ack_core_en", bus.core_en, 1'b0);
    bus.mem_ack = 1'b0;

    // Zero-wait stream: pc 0..3, one issue every 2 cycles
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    pc_m    = 8'h00;
    bus.pc  = pc_m;
    bus.run = 1'b1;
    tick();
    check1("start_mem_req", bus.mem_req, 1'b1);
    for (int n = 0; n < 4; n++) do_instr(0, (n < 3), 1'b0);
    tick();
    check1("stream_idle_mem_req", bus.mem_req, 1'b0);

    // Ack delayed 3 cycles: request held 4 cycles, single issue pulse
    mem[pc_m] = 8'h21;
    bus.run   = 1'b1;
    tick();
    do_instr(3, 1'b0, 1'b0);
    tick();
    check1("delay_single_pulse", bus.core_en, 1'b0);
    check1("delay_idle_mem_req", bus.mem_req, 1'b0);

    // Randomized traffic: random memory image (no halts), random start pc and ack delays
    for (int k = 0; k < 256; k++) begin
      mem[k] = 8'($urandom);
      if (mem[k][7:4] == HALT_OP) mem[k][7:4] = 4'h3;
    end
    pc_m    = 8'($urandom);
    bus.pc  = pc_m;
    bus.run = 1'b1;
    tick();
    for (int n = 0; n < 24; n++) do_instr(int'($urandom_range(0, 4)), (n < 23), 1'b0);
    tick();
    check1("rand_idle_mem_req", bus.mem_req, 1'b0);

    // run dropped during a waiting request: transaction still completes, then idle
    bus.run = 1'b1;
    tick();
    do_instr(3, 1'b0, 1'b1);
    tick();
    check1("drop_idle_mem_req", bus.mem_req, 1'b0);
    check1("drop_idle_core_en", bus.core_en, 1'b0);

    // Halt opcode at pc=2: issued, then halted with no further requests
    mem[0] = 8'h1A; mem[1] = 8'h2B; mem[2] = 8'hF0;
    pc_m    = 8'h00;
    bus.pc  = pc_m;
    bus.run = 1'b1;
    tick();
    do_instr(0, 1'b1, 1'b0);
    do_instr(0, 1'b1, 1'b0);
    do_instr(0, 1'b1, 1'b0);
    check8("halt_ins", bus.input_ins, 8'hF0);
    repeat (4) begin
      tick();
      check1("halt_hold_halted", bus.halted, 1'b1);
      check1("halt_hold_mem_req", bus.mem_req, 1'b0);
      check1("halt_hold_core_en", bus.core_en, 1'b0);
    end
    bus.run = 1'b0;
    tick();
    check1("unhalt_halted", bus.halted, 1'b0);
    check1("unhalt_mem_req", bus.mem_req, 1'b0);
    tick();
    check1("unhalt_idle_mem_req", bus.mem_req, 1'b0);

    // Request with no ack
    bus.run = 1'b1;
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      check1("to_wait_mem_req", bus.mem_req, 1'b1);
      check1("to_wait_err", bus.err, 1'b0);
      tick();
    end
    check1("to_err", bus.err, 1'b1);
    check1("to_mem_req", bus.mem_req, 1'b0);
    bus.run       = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h77;
    repeat (3) tick();
    check1("to_sticky_err", bus.err, 1'b1);
    check1("to_sticky_mem_req", bus.mem_req, 1'b0);
    check1("to_sticky_core_en", bus.core_en, 1'b0);
    bus.mem_ack = 1'b0;
    CLB = 1'b0;
    #1;
    check1("to_rst_err", bus.err, 1'b0);
    #1;
    CLB      = 1'b1;
    last_ins = 8'h00;
    bus.run  = 1'b1;
    tick();
    tick();
`else
    for (int i = 0; i < 40; i++) begin
      check1("nto_wait_mem_req", bus.mem_req, 1'b1);
      check1("nto_wait_err", bus.err, 1'b0);
      tick();
    end
`endif

    // Asynchronous reset in the middle of a waiting request
    check1("mid_req_mem_req", bus.mem_req, 1'b1);
    #2;
    CLB = 1'b0;
    #1;
    check1("arst_mem_req", bus.mem_req, 1'b0);
    check1("arst_core_en", bus.core_en, 1'b0);
    check8("arst_ins", bus.input_ins, 8'h00);
    check1("arst_halted", bus.halted, 1'b0);
    check1("arst_err", bus.err, 1'b0);
    #1;
    CLB           = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h5A;
    tick();
    tick();
    check8("late_ack_ins", bus.input_ins, 8'h00);
    check1("late_ack_mem_req", bus.mem_req, 1'b0);
    check1("late_ack_core_en", bus.core_en, 1'b0);
    bus.mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
